player_seq_ctrl: RTL and testbench

Parametrised successor to the single-purpose player/volume control pair. It owns playback of one of TRACKS selectable tracks: beat counter, play/pause/done state machine, repeat, track switching and a saturating volume register with mute gating. It sits between the user switches/buttons and the music ROM / note generator. It runs entirely on the crystal clock and advances the beat on a one-cycle beat_tick strobe, so the whole block uses one clock.

---
 rtl/player_seq_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_player_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_seq_ctrl.sv
// player_seq_ctrl
// Playback controller for one of TRACKS tracks. It holds the beat counter,
// the IDLE/PLAY/PAUSE/DONE state machine, repeat and track switching, and a
// saturating volume register. Every output is a register. One clock domain.
//
// Input timing: beat_tick is a one-cycle strobe. It is counted only on the
// clock edge where it is high and the machine is in PLAY. play, repeat_en,
// mute and track_sel are levels sampled on every edge. vol_up and vol_down are
// raw button levels. Each 0->1 transition gives exactly one volume step, no
// matter how long the button is held.
module player_seq_ctrl #(
    parameter int TRACKS   = 2,
    parameter int TRK_W    = 1,
    parameter int BEAT_W   = 12,
    parameter int VOL_MAX  = 5,
    parameter int VOL_W    = 3,
    parameter int VOL_INIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     beat_tick,
    input  logic                     play,
    input  logic                     repeat_en,
    input  logic                     mute,
    input  logic [TRK_W-1:0]         track_sel,
    input  logic [TRACKS*BEAT_W-1:0] track_len,
    input  logic                     vol_up,
    input  logic                     vol_down,
    output logic [BEAT_W-1:0]        beat,
    output logic [TRK_W-1:0]         track,
    output logic [1:0]               state,
    output logic                     sound_en,
    output logic [VOL_W-1:0]         vol
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [VOL_W-1:0] VOL_TOP  = VOL_W'(VOL_MAX);
    localparam logic [VOL_W-1:0] VOL_BOT  = VOL_W'(1);
    localparam logic [VOL_W-1:0] VOL_RST  = VOL_W'(VOL_INIT);

    // Registered state
    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [TRK_W-1:0]    track_q;
    logic                sound_q;
    logic [VOL_W-1:0]    vol_q;

    // Edge-detect history of the previous cycle's button / repeat levels
    logic                up_q;
    logic                down_q;
    logic                rep_q;

    // Next-state values
    state_t              state_d;
    logic [BEAT_W-1:0]   beat_d;
    logic [TRK_W-1:0]    track_d;
    logic                sound_d;
    logic [VOL_W-1:0]    vol_d;

    // Derived signals
    logic [TRK_W-1:0]    sel_mapped;
    logic [BEAT_W-1:0]   raw_len;
    logic [BEAT_W-1:0]   last_beat;
    logic                at_end;
    logic                up_edge;
    logic                down_edge;
    logic                rep_edge;

    // Map the requested track. Indices outside 0..TRACKS-1 become track 0.
    always_comb begin
        sel_mapped = '0;
        for (int i = 0; i < TRACKS; i++) begin
            if (track_sel == TRK_W'(i)) begin
                sel_mapped = TRK_W'(i);
            end
        end
    end

    // Select the length of the latched track from the packed length bus
    always_comb begin
        raw_len = track_len[BEAT_W-1:0];
        for (int i = 0; i < TRACKS; i++) begin
            if (track_q == TRK_W'(i)) begin
                raw_len = track_len[i*BEAT_W +: BEAT_W];
            end
        end
    end

    // Compute the last beat index. A length of 0 counts as 1, so the last
    // beat is 0 in that case. The >= compare also catches a length that
    // shrinks below the current beat.
    assign last_beat = (raw_len == '0) ? '0 : (raw_len - 1'b1);
    assign at_end    = (beat_q >= last_beat);

    assign up_edge   = vol_up    & ~up_q;
    assign down_edge = vol_down  & ~down_q;
    assign rep_edge  = repeat_en & ~rep_q;

    // Compute the next playback state, beat and track
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        track_d = track_q;

        if (sel_mapped != track_q) begin
            // A track change outranks every other event in every state
            track_d = sel_mapped;
            beat_d  = '0;
            if (play) begin
                state_d = ST_PLAY;
            end else if (state_q == ST_PLAY || state_q == ST_PAUSE) begin
                state_d = ST_PAUSE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        state_d = ST_PLAY;
                        beat_d  = '0;
                    end
                end
                ST_PLAY: begin
                    // Pause wins over a beat_tick in the same cycle
                    if (!play) begin
                        state_d = ST_PAUSE;
                    end else if (beat_tick) begin
                        if (!at_end) begin
                            beat_d = beat_q + 1'b1;
                        end else if (repeat_en) begin
                            beat_d = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (play) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_DONE: begin
                    if (!play) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else if (rep_edge) begin
                        state_d = ST_PLAY;
                        beat_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end
            endcase
        end

        // Taken from the next state so it lines up with the state register
        sound_d = (state_d == ST_PLAY) && !mute;
    end

    // Register the playback state, beat, track and sound gate
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            track_q <= '0;
            sound_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            track_q <= track_d;
            sound_q <= sound_d;
        end
    end

    // Compute the next volume: saturating step. Opposing edges cancel.
    always_comb begin
        vol_d = vol_q;
        if (up_edge && !down_edge) begin
            if (vol_q < VOL_TOP) begin
                vol_d = vol_q + 1'b1;
            end
        end else if (down_edge && !up_edge) begin
            if (vol_q > VOL_BOT) begin
                vol_d = vol_q - 1'b1;
            end
        end
    end

    // Register the volume level. It does not depend on state or mute.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vol_q <= VOL_RST;
        end else begin
            vol_q <= vol_d;
        end
    end

    // Store the previous-cycle levels for button and repeat edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            rep_q  <= 1'b0;
        end else begin
            up_q   <= vol_up;
            down_q <= vol_down;
            rep_q  <= repeat_en;
        end
    end

    assign beat     = beat_q;
    assign track    = track_q;
    assign state    = state_q;
    assign sound_en = sound_q;
    assign vol      = vol_q;

endmodule

// File: tb/tb_player_seq_ctrl.sv
// tb_player_seq_ctrl
// A behavioural model predicts every clock edge and pushes the expected
// output bundle into a queue. A monitor pops one entry after each rising
// edge and compares it against the DUT. Directed sequences walk the main
// scenarios. Randomised traffic follows.
module tb_player_seq_ctrl;

    localparam int TRACKS   = 2;
    localparam int TRK_W    = 2;
    localparam int BEAT_W   = 12;
    localparam int VOL_MAX  = 5;
    localparam int VOL_W    = 3;
    localparam int VOL_INIT = 3;
    localparam int W        = BEAT_W + TRK_W + 2 + 1 + VOL_W;

    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    // ---------------- clock / reset / DUT ----------------
    logic                     clk = 1'b0;
    logic                     rst;
    logic                     beat_tick;
    logic                     play;
    logic                     repeat_en;
    logic                     mute;
    logic [TRK_W-1:0]         track_sel;
    logic [TRACKS*BEAT_W-1:0] track_len;
    logic                     vol_up;
    logic                     vol_down;
    logic [BEAT_W-1:0]        beat;
    logic [TRK_W-1:0]         track;
    logic [1:0]               state;
    logic                     sound_en;
    logic [VOL_W-1:0]         vol;

    always #5 clk = ~clk;

    player_seq_ctrl #(
        .TRACKS  (TRACKS),
        .TRK_W   (TRK_W),
        .BEAT_W  (BEAT_W),
        .VOL_MAX (VOL_MAX),
        .VOL_W   (VOL_W),
        .VOL_INIT(VOL_INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .beat_tick(beat_tick),
        .play     (play),
        .repeat_en(repeat_en),
        .mute     (mute),
        .track_sel(track_sel),
        .track_len(track_len),
        .vol_up   (vol_up),
        .vol_down (vol_down),
        .beat     (beat),
        .track    (track),
        .state    (state),
        .sound_en (sound_en),
        .vol      (vol)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit running  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state, m_beat, m_track, m_sound, m_vol;
    bit m_up, m_dn, m_rep;

    task automatic model_step();
        int nsel, len, ns, nb;
        bit up_e, dn_e, rep_e;
        if (!rst) begin
            m_state = S_IDLE; m_beat = 0; m_track = 0; m_sound = 0;
            m_vol = VOL_INIT; m_up = 0; m_dn = 0; m_rep = 0;
        end else begin
            up_e  = vol_up && !m_up;
            dn_e  = vol_down && !m_dn;
            rep_e = repeat_en && !m_rep;
            nsel  = (int'(track_sel) < TRACKS) ? int'(track_sel) : 0;
            len   = int'((track_len >> (m_track * BEAT_W)) & ((1 << BEAT_W) - 1));
            if (len == 0) len = 1;
            ns = m_state;
            nb = m_beat;
            if (nsel != m_track) begin
                m_track = nsel;
                nb = 0;
                if (play) ns = S_PLAY;
                else if (m_state == S_PLAY || m_state == S_PAUSE) ns = S_PAUSE;
            end else if (m_state == S_IDLE) begin
                if (play) begin ns = S_PLAY; nb = 0; end
            end else if (m_state == S_PLAY) begin
                if (!play) ns = S_PAUSE;
                else if (beat_tick) begin
                    if (m_beat < len - 1) nb = m_beat + 1;
                    else if (repeat_en) nb = 0;
                    else ns = S_DONE;
                end
            end else if (m_state == S_PAUSE) begin
                if (play) ns = S_PLAY;
            end else begin
                if (!play) begin ns = S_IDLE; nb = 0; end
                else if (rep_e) begin ns = S_PLAY; nb = 0; end
            end
            m_state = ns;
            m_beat  = nb;
            m_sound = (ns == S_PLAY && !mute) ? 1 : 0;
            if (up_e && !dn_e) m_vol = (m_vol < VOL_MAX) ? m_vol + 1 : VOL_MAX;
            else if (dn_e && !up_e) m_vol = (m_vol > 1) ? m_vol - 1 : 1;
            m_up = vol_up; m_dn = vol_down; m_rep = repeat_en;
        end
        exp_q.push_back({BEAT_W'(m_beat), TRK_W'(m_track), 2'(m_state),
                         1'(m_sound), VOL_W'(m_vol)});
        running = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() == 0) begin
            if (running) chk("queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("beat",     32'(beat),     32'(e[W-1 -: BEAT_W]));
            chk("track",    32'(track),    32'(e[VOL_W+3+TRK_W-1 -: TRK_W]));
            chk("state",    32'(state),    32'(e[VOL_W+2 -: 2]));
            chk("sound_en", 32'(sound_en), 32'(e[VOL_W]));
            chk("vol",      32'(vol),      32'(e[VOL_W-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs are set at the falling edge, then predicted and held over the rise
    task automatic cyc();
        model_step();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_len(input int l0, input int l1);
        logic [BEAT_W-1:0] a, b;
        a = BEAT_W'(l0);
        b = BEAT_W'(l1);
        track_len = {b, a};
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; play = 1'b1; beat_tick = 1'b0; repeat_en = 1'b0; mute = 1'b0;
        track_sel = '0; vol_up = 1'b0; vol_down = 1'b0;
        set_len(4, 10);
        @(negedge clk);

        // Reset with play held high
        cycles(3);
        chk("rst_state", 32'(state), S_IDLE);
        chk("rst_beat",  32'(beat), 0);
        chk("rst_vol",   32'(vol), VOL_INIT);
        chk("rst_sound", 32'(sound_en), 0);
        rst = 1'b1;
        cyc();
        chk("post_rst_play", 32'(state), S_PLAY);

        // End of track without repeat, then restart on the repeat_en rising edge
        beat_tick = 1'b1;
        cycles(4);
        chk("done_state", 32'(state), S_DONE);
        chk("done_beat",  32'(beat), 3);
        beat_tick = 1'b0; repeat_en = 1'b1;
        cyc();
        chk("rep_restart", 32'(state), S_PLAY);
        beat_tick = 1'b1;
        cycles(4);
        chk("wrap_beat",  32'(beat), 0);
        chk("wrap_state", 32'(state), S_PLAY);

        // Pause takes priority over a tick in the same cycle. Ticks are ignored while paused.
        set_len(20, 10);
        cycles(5);
        play = 1'b0;
        cyc();
        chk("pause_state", 32'(state), S_PAUSE);
        chk("pause_beat",  32'(beat), 5);
        cycles(3);
        chk("paused_hold", 32'(beat), 5);
        play = 1'b1; beat_tick = 1'b0;
        cyc();
        beat_tick = 1'b1;
        cyc();
        chk("resume_beat", 32'(beat), 6);

        // Track switching, including an out-of-range index
        cyc();
        track_sel = 2'd1; beat_tick = 1'b0;
        cyc();
        chk("sw_track", 32'(track), 1);
        chk("sw_beat",  32'(beat), 0);
        track_sel = 2'd3;
        cyc();
        chk("sw_oor_track", 32'(track), 0);
        track_sel = 2'd0;

        // Volume: six up pulses, held down, both at once, six down pulses
        for (int i = 0; i < 6; i++) begin
            vol_up = 1'b1; cyc(); vol_up = 1'b0; cyc();
        end
        chk("vol_ceiling", 32'(vol), VOL_MAX);
        vol_down = 1'b1; cycles(10); vol_down = 1'b0; cyc();
        chk("vol_held", 32'(vol), VOL_MAX - 1);
        vol_up = 1'b1; vol_down = 1'b1; cyc(); vol_up = 1'b0; vol_down = 1'b0; cyc();
        chk("vol_both", 32'(vol), VOL_MAX - 1);
        for (int i = 0; i < 6; i++) begin
            vol_down = 1'b1; cyc(); vol_down = 1'b0; cyc();
        end
        chk("vol_floor", 32'(vol), 1);

        // Mute gates sound while beats keep advancing
        beat_tick = 1'b1; mute = 1'b1;
        cyc();
        chk("mute_sound", 32'(sound_en), 0);
        cycles(3);
        mute = 1'b0;
        cyc();
        chk("unmute_sound", 32'(sound_en), 1);

        // Random traffic with short tracks, so ends, wraps and shrinks happen often
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) != 0);
            beat_tick = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0)  play      = ~play;
            if ($urandom_range(0, 15) == 0) repeat_en = ~repeat_en;
            if ($urandom_range(0, 7) == 0)  mute      = ~mute;
            if ($urandom_range(0, 39) == 0) track_sel = TRK_W'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) set_len($urandom_range(0, 9), $urandom_range(0, 9));
            vol_up   = ($urandom_range(0, 3) == 0);
            vol_down = ($urandom_range(0, 3) == 0);
            cyc();
        end

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
